// File: rtl/speed_tick_gen_if.sv
// Control/status bundle between the game FSM and the speed timebase.
// The game side drives the speed request; the timebase returns tick, toggle and level status.
interface speed_tick_gen_if #(
    parameter int LVL_W = 2
);
    logic             Enable;
    logic [LVL_W-1:0] Level;
    logic             AutoMode;
    logic             Tick;
    logic             Toggle;
    logic [LVL_W-1:0] CurLevel;
    logic             AtMax;

    modport master (
        output Enable, Level, AutoMode,
        input  Tick, Toggle, CurLevel, AtMax
    );

    modport slave (
        input  Enable, Level, AutoMode,
        output Tick, Toggle, CurLevel, AtMax
    );
endinterface

// File: rtl/speed_tick_gen.sv
// Game-speed timebase: one divider whose period is BASE_DIV >> level, with a
// one-cycle Tick, a Toggle square wave, and an optional self-accelerating level.
module speed_tick_gen #(
    parameter int BASE_DIV    = 25000000,
    parameter int NUM_LEVELS  = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int CNT_W       = 26,
    parameter int LVL_W       = 2
) (
    input  logic           Clock,
    input  logic           Resetn,
    speed_tick_gen_if.slave bus
);
    localparam int ACC_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(ACCEL_TICKS - 1);
    localparam logic [LVL_W-1:0] TOP_LVL   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W:0]   BASE_FULL = (CNT_W + 1)'(BASE_DIV);

    if (BASE_DIV > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("speed_tick_gen: BASE_DIV does not fit in CNT_W");
    end
    if ((1 << LVL_W) < NUM_LEVELS) begin : g_bad_lvl_w
        $error("speed_tick_gen: LVL_W too narrow for NUM_LEVELS");
    end
    if ((BASE_DIV >> (NUM_LEVELS - 1)) < 2) begin : g_bad_div
        $error("speed_tick_gen: fastest divisor must be at least 2");
    end
    if (ACCEL_TICKS < 1) begin : g_bad_accel
        $error("speed_tick_gen: ACCEL_TICKS must be at least 1");
    end

    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic [LVL_W-1:0] cur_level;
    logic             tick;
    logic             toggle;
    logic             at_max;

    logic [CNT_W:0]   div_full;
    logic [CNT_W-1:0] last_cnt;
    logic [LVL_W-1:0] level_req;
    logic             level_change;
    logic             terminal;

    // div_full is one bit wider so BASE_DIV == 2^CNT_W still works; its minus-one fits CNT_W.
    assign div_full     = BASE_FULL >> cur_level;
    assign last_cnt     = CNT_W'(div_full - 1'b1);
    assign level_req    = (bus.Level > TOP_LVL) ? TOP_LVL : bus.Level;
    assign level_change = !bus.AutoMode && (level_req != cur_level);
    assign terminal     = (count == last_cnt);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count     <= '0;
            acc       <= '0;
            cur_level <= '0;
            tick      <= 1'b0;
            toggle    <= 1'b0;
            at_max    <= (TOP_LVL == '0);
        end else begin
            tick <= 1'b0;
            if (level_change) begin
                // Manual level is sampled even while paused; a coincident terminal count is dropped.
                cur_level <= level_req;
                at_max    <= (level_req == TOP_LVL);
                count     <= '0;
            end else if (bus.Enable) begin
                if (terminal) begin
                    count  <= '0;
                    tick   <= 1'b1;
                    toggle <= ~toggle;
                    if (bus.AutoMode) begin
                        if (acc == ACC_LAST) begin
                            acc <= '0;
                            if (cur_level != TOP_LVL) begin
                                cur_level <= cur_level + 1'b1;
                                at_max    <= ((cur_level + 1'b1) == TOP_LVL);
                            end
                        end else begin
                            acc <= acc + 1'b1;
                        end
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (!bus.AutoMode) begin
                acc <= '0;
            end
        end
    end

    assign bus.Tick     = tick;
    assign bus.Toggle   = toggle;
    assign bus.CurLevel = cur_level;
    assign bus.AtMax    = at_max;
endmodule

// File: tb/tb_speed_tick_gen.sv
// Bench for speed_tick_gen: a directed table of hand-computed checkpoints, then
// randomized traffic compared cycle by cycle against a reference model.
module tb_speed_tick_gen;
    localparam int BASE_DIV    = 16;
    localparam int NUM_LEVELS  = 4;
    localparam int ACCEL_TICKS = 3;
    localparam int CNT_W       = 4;
    localparam int LVL_W       = 3;
    localparam int W           = 6;

    logic Clock;
    logic Resetn;

    speed_tick_gen_if #(.LVL_W(LVL_W)) bus ();

    speed_tick_gen #(
        .BASE_DIV   (BASE_DIV),
        .NUM_LEVELS (NUM_LEVELS),
        .ACCEL_TICKS(ACCEL_TICKS),
        .CNT_W      (CNT_W),
        .LVL_W      (LVL_W)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus.slave)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // reference model: elapsed cycles in the current period and ticks spent at the level
    int m_lvl, m_phase, m_nticks;
    bit m_tick, m_tog;

    function automatic logic [W-1:0] pk(bit t, bit g, int c, bit a);
        logic [2:0] c3;
        c3 = 3'(c);
        return {t, g, c3, a};
    endfunction

    function automatic logic [W-1:0] model_step(bit rstn, bit en, int lvl, bit auto_m);
        int req;
        if (!rstn) begin
            m_lvl = 0; m_phase = 0; m_nticks = 0; m_tick = 0; m_tog = 0;
        end else begin
            m_tick = 0;
            req = (lvl >= NUM_LEVELS) ? NUM_LEVELS - 1 : lvl;
            if (!auto_m && req != m_lvl) begin
                m_lvl   = req;
                m_phase = 0;
            end else if (en) begin
                m_phase++;
                if (m_phase == BASE_DIV / (1 << m_lvl)) begin
                    m_phase = 0;
                    m_tick  = 1;
                    m_tog   = !m_tog;
                    if (auto_m) begin
                        m_nticks++;
                        if (m_nticks == ACCEL_TICKS) begin
                            m_nticks = 0;
                            if (m_lvl < NUM_LEVELS - 1) m_lvl++;
                        end
                    end
                end
            end
            if (!auto_m) m_nticks = 0;
        end
        return pk(m_tick, m_tog, m_lvl, m_lvl == NUM_LEVELS - 1);
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {bus.Tick, bus.Toggle, bus.CurLevel, bus.AtMax};
    endfunction

    // driver: one clock edge with the given inputs, then scoreboard against the model
    task automatic step_cycle(input bit rstn, input bit en, input int lvl, input bit auto_m,
                              output bit tick_seen);
        logic [W-1:0] exp_v, act_v;
        Resetn       = rstn;
        bus.Enable   = en;
        bus.Level    = LVL_W'(lvl);
        bus.AutoMode = auto_m;
        @(posedge Clock);
        #1;
        exp_q.push_back(model_step(rstn, en, lvl, auto_m));
        exp_v = exp_q.pop_front();
        act_v = dut_out();
        tick_seen = bus.Tick;
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cycle t=%0t got tick/tog/lvl/max=%b required %b", $time, act_v, exp_v);
        end
    endtask

    typedef struct {
        bit          rstn;
        bit          en;
        bit          auto_m;
        int          lvl;
        int          cycles;
        logic [W-1:0] exp_out;
        int          exp_ticks;
    } vec_t;

    vec_t tbl[$];

    task automatic add(bit rstn, bit en, bit auto_m, int lvl, int cycles, logic [W-1:0] eo, int et);
        vec_t v;
        v.rstn = rstn; v.en = en; v.auto_m = auto_m; v.lvl = lvl;
        v.cycles = cycles; v.exp_out = eo; v.exp_ticks = et;
        tbl.push_back(v);
    endtask

    initial begin
        bit ts;
        int nt;
        logic [W-1:0] act_v;
        bit r_rstn, r_en, r_auto;
        int r_lvl;

        Resetn = 1'b0; bus.Enable = 1'b0; bus.Level = '0; bus.AutoMode = 1'b0;

        //   rstn en auto lvl cyc  expected {tick,tog,lvl,max}   ticks
        add(0, 1, 0, 0,  2, pk(0, 0, 0, 0), 0);   // reset state
        add(1, 1, 0, 0, 15, pk(0, 0, 0, 0), 0);   // count reaches 15, no tick yet
        add(1, 1, 0, 0,  1, pk(1, 1, 0, 0), 1);   // first tick on 16th edge
        add(1, 1, 0, 0, 48, pk(1, 0, 0, 0), 3);   // ticks at 32,48,64
        add(1, 1, 0, 2,  1, pk(0, 0, 2, 0), 0);   // level change to 2
        add(1, 1, 0, 2, 20, pk(1, 1, 2, 0), 5);   // period 4
        add(1, 1, 0, 2,  2, pk(0, 1, 2, 0), 0);   // mid-period
        add(1, 0, 0, 2, 10, pk(0, 1, 2, 0), 0);   // paused: nothing moves
        add(1, 1, 0, 2,  1, pk(0, 1, 2, 0), 0);   // resume from held count
        add(1, 1, 0, 2,  1, pk(1, 0, 2, 0), 1);   // tick after remaining count only
        add(1, 1, 0, 0,  1, pk(0, 0, 0, 0), 0);
        add(1, 1, 0, 0, 15, pk(0, 0, 0, 0), 0);   // count == 15
        add(1, 1, 0, 3,  1, pk(0, 0, 3, 1), 0);   // change wins over terminal count
        add(1, 1, 0, 3,  1, pk(0, 0, 3, 1), 0);
        add(1, 1, 0, 3,  1, pk(1, 1, 3, 1), 1);   // tick 2 cycles after change
        add(1, 1, 0, 6,  1, pk(0, 1, 3, 1), 0);   // out-of-range clamps to 3, no change
        add(1, 1, 0, 6,  1, pk(1, 0, 3, 1), 1);
        add(1, 1, 0, 1,  1, pk(0, 0, 1, 0), 0);
        add(1, 1, 0, 6,  1, pk(0, 0, 3, 1), 0);   // clamp from level 1
        add(1, 1, 0, 0,  1, pk(0, 0, 0, 0), 0);
        add(1, 1, 1, 5, 47, pk(0, 0, 0, 0), 2);   // auto: Level input ignored
        add(1, 1, 1, 5,  1, pk(1, 1, 1, 0), 1);   // 3rd tick raises level
        add(1, 1, 1, 5, 24, pk(1, 0, 2, 0), 3);   // period 8
        add(1, 1, 1, 5, 12, pk(1, 1, 3, 1), 3);   // period 4, AtMax on 9th tick
        add(1, 1, 1, 5, 10, pk(1, 0, 3, 1), 5);   // period 2 at max
        add(1, 1, 0, 2,  1, pk(0, 0, 2, 0), 0);   // auto off: Level applied
        add(1, 1, 1, 2,  2, pk(0, 0, 2, 0), 0);
        add(0, 1, 1, 2,  1, pk(0, 0, 0, 0), 0);   // reset mid-period
        add(1, 1, 1, 2, 15, pk(0, 0, 0, 0), 0);
        add(1, 1, 1, 2,  1, pk(1, 1, 0, 0), 1);   // full BASE_DIV after release

        for (int i = 0; i < tbl.size(); i++) begin
            nt = 0;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                step_cycle(tbl[i].rstn, tbl[i].en, tbl[i].lvl, tbl[i].auto_m, ts);
                nt += int'(ts);
            end
            act_v = dut_out();
            checks++;
            if (act_v !== tbl[i].exp_out) begin
                errors++;
                $display("FAIL vec%0d_out got %b required %b", i, act_v, tbl[i].exp_out);
            end
            checks++;
            if (nt != tbl[i].exp_ticks) begin
                errors++;
                $display("FAIL vec%0d_ticks got %0d required %0d", i, nt, tbl[i].exp_ticks);
            end
        end

        // randomized traffic against the model
        r_en = 1; r_auto = 0; r_lvl = 0;
        for (int c = 0; c < 4000; c++) begin
            r_rstn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) == 0)  r_en   = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 39) == 0) r_lvl  = $urandom_range(0, 7);
            if ($urandom_range(0, 149) == 0) r_auto = !r_auto;
            step_cycle(r_rstn, r_en, r_lvl, r_auto, ts);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/speed_tick_gen.md
Name: speed_tick_gen

Overview:
Parametrised game-speed timebase. It replaces the fixed half/quarter/eighth-second dividers with a single counter that supports NUM_LEVELS speed levels. Level k uses a divisor of BASE_DIV >> k. It emits a one-cycle Tick pulse and a 50%-duty Toggle square wave for the game FSM. It also has an auto-accelerate mode that raises the level after every ACCEL_TICKS ticks.

Parameters:
BASE_DIV, 25000000, divisor for level 0 in clock cycles (at 50 MHz: Tick every 0.5 s, Toggle period 1 s)
NUM_LEVELS, 4, number of speed levels; level k divisor = BASE_DIV >> k
ACCEL_TICKS, 8, ticks spent at each level before auto-increment (must be >= 1)
CNT_W, 26, divider counter width; must satisfy BASE_DIV <= 2^CNT_W
LVL_W, 2, level field width; must satisfy 2^LVL_W >= NUM_LEVELS
Constraint: BASE_DIV >> (NUM_LEVELS-1) >= 2. Violations are a synthesis-time error.

Ports:
Clock  input  1  system clock; single clock domain
Resetn  input  1  synchronous, active-low reset
Enable  input  1  1 = counter runs; 0 = pause (all state holds)
Level  input  LVL_W  requested level in manual mode
AutoMode  input  1  1 = self-accelerating level; 0 = level follows Level input
Tick  output  1  one-cycle pulse once per divisor period
Toggle  output  1  flips on every Tick
CurLevel  output  LVL_W  level currently in effect
AtMax  output  1  high while CurLevel == NUM_LEVELS-1

Behaviour:
- Reset (Resetn=0 at a rising edge): count=0, Tick=0, Toggle=0, CurLevel=0, accel counter=0, AtMax=0 (or 1 if NUM_LEVELS=1). Reset overrides every other input.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- DIV = BASE_DIV >> CurLevel.
- Divider (Enable=1, no level change this cycle):
  - count < DIV-1: count increments; Tick<=0.
  - count == DIV-1: count<=0; Tick<=1; Toggle<=~Toggle.
- Divider timing: with Enable held high, Tick is high for exactly 1 cycle every DIV cycles. The first Tick after reset release follows the DIV-th enabled edge.
- Enable=0: count, Toggle, CurLevel and accel counter hold; Tick<=0. Resuming continues from the held count, with no extra or lost tick.
- Manual mode (AutoMode=0):
  - Next level = Level, clamped to NUM_LEVELS-1 when Level >= NUM_LEVELS.
  - The accel counter is held at 0.
  - The level is sampled every cycle, including when Enable=0.
- Level change (next level != CurLevel):
  - CurLevel updates, count<=0, Tick<=0, Toggle holds.
  - A change takes priority over a coincident terminal count: that tick is dropped.
  - The new DIV applies from the following cycle.
- Auto mode (AutoMode=1):
  - The Level input is ignored; CurLevel is held except for auto-increment.
  - On each emitted Tick: if accel counter == ACCEL_TICKS-1, the counter is cleared and CurLevel increments (saturating at NUM_LEVELS-1); otherwise the counter increments.
  - The increment happens on the Tick edge itself. Since count is already 0, the new DIV governs the next period and no tick is dropped.
  - At max level, the accel counter keeps wrapping but CurLevel stays put.
- AutoMode 0->1: starts from the current CurLevel with accel counter=0.
- AutoMode 1->0: Level is applied next cycle using the level-change rule.
- AtMax is registered alongside CurLevel and always consistent with it.
- Reset mid-period: the count is discarded, and the next Tick comes a full BASE_DIV after release.

Test Plan:
All scenarios use BASE_DIV=16, NUM_LEVELS=4, ACCEL_TICKS=3 (DIVs 16/8/4/2).
- Reset then Enable=1, AutoMode=0, Level=0 for 64 cycles -> Ticks at cycles 16, 32, 48, 64, each 1 cycle wide; Toggle sequence 1,0,1,0; CurLevel=0.
- Level=2 for 20 cycles, then Enable=0 for 10 cycles, then Enable=1 -> Tick period 4; no Tick while paused; first Tick after resume comes after the remaining count (no restart).
- Level changes 0->3 on the cycle count==15 -> no Tick that cycle; count restarts; next Tick 2 cycles later; Toggle unchanged across the change; CurLevel=3, AtMax=1.
- Level=3'b? out of range (LVL_W=3, Level=6) -> CurLevel clamps to 3.
- AutoMode=1 from level 0 -> 3 ticks at period 16, 3 at 8, 3 at 4, then period 2 indefinitely; AtMax rises on the 9th Tick edge; no dropped tick at any transition.
- Resetn=0 for 1 cycle mid-period at level 2 in auto mode -> next cycle all outputs 0, CurLevel=0; next Tick 16 cycles after release.
